// File: rtl/fp_mul_iter.sv
// fp_mul_iter: iterative IEEE-754-style floating-point multiplier.
// One RTL serves binary32 (EXP_W=8, MAN_W=23) and binary64 (EXP_W=11, MAN_W=52).
// The mantissa product is built by a shift-add loop, one multiplier bit per
// cycle. Subnormal inputs are flushed to zero. Results that overflow saturate
// to signed Inf, and results that underflow flush to signed zero.
// Optional macro FP_MUL_RNE_EN: when defined, rounding is round-to-nearest-even.
// When it is undefined, results are truncated (round toward zero). Latency is
// the same in both builds.
module fp_mul_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int M     = MAN_W + 1;          // significand width incl. hidden bit
    localparam int P_W   = 2 * M;              // full product width
    localparam int CNT_W = $clog2(M);

    localparam logic signed [EXP_W+1:0] BIAS_S    = (EXP_W+2)'((1 << (EXP_W-1)) - 1);
    localparam logic signed [EXP_W+1:0] EXP_INF_S = (EXP_W+2)'((1 << EXP_W) - 1);
    localparam logic signed [EXP_W+1:0] ONE_S     = (EXP_W+2)'(1);
    localparam logic signed [EXP_W+1:0] ZERO_S    = (EXP_W+2)'(0);

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_MUL   = 3'd2;
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [M-1:0]     r_mplier;
    logic [P_W-1:0]   r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_special;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [W-1:0]     r_result;
    logic             r_ovf;
    logic             r_unf;

    // Operand field decode (operands are held in r_a/r_b after accept)
    logic [EXP_W-1:0] w_a_exp, w_b_exp;
    logic [MAN_W-1:0] w_a_frac, w_b_frac;
    logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic             w_sign;

    assign w_a_exp  = r_a[W-2:MAN_W];
    assign w_b_exp  = r_b[W-2:MAN_W];
    assign w_a_frac = r_a[MAN_W-1:0];
    assign w_b_frac = r_b[MAN_W-1:0];
    assign w_a_zero = (w_a_exp == {EXP_W{1'b0}});
    assign w_b_zero = (w_b_exp == {EXP_W{1'b0}});
    assign w_a_inf  = (&w_a_exp) & ~(|w_a_frac);
    assign w_b_inf  = (&w_b_exp) & ~(|w_b_frac);
    assign w_a_nan  = (&w_a_exp) & (|w_a_frac);
    assign w_b_nan  = (&w_b_exp) & (|w_b_frac);
    assign w_sign   = r_a[W-1] ^ r_b[W-1];

    // Special-value classification: NaN, Inf and zero short-circuit the multiply
    logic         w_is_special;
    logic [W-1:0] w_spec_val;

    // Pick the special result (if any) for the latched operands
    always_comb begin
        w_is_special = 1'b1;
        w_spec_val   = {W{1'b0}};
        if (w_a_nan | w_b_nan | (w_a_zero & w_b_inf) | (w_a_inf & w_b_zero)) begin
            w_spec_val = QNAN;
        end else if (w_a_inf | w_b_inf) begin
            w_spec_val = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_a_zero | w_b_zero) begin
            w_spec_val = {w_sign, {(W-1){1'b0}}};
        end else begin
            w_is_special = 1'b0;
        end
    end

    // Shift-add step: add the multiplicand into the upper half when the bit is set
    logic [M-1:0] w_mcand;
    logic [M:0]   w_sum;

    assign w_mcand = {1'b1, w_a_frac};
    assign w_sum   = {1'b0, r_acc[P_W-1:M]} + (r_mplier[0] ? {1'b0, w_mcand} : {(M+1){1'b0}});

    // Normalisation: product lies in [1,4), so at most a one-bit right shift
    logic [MAN_W-1:0] w_frac_sel;
    logic             w_guard;
    logic             w_sticky;

    // Select the kept fraction plus guard/sticky depending on the product MSB
    always_comb begin
        w_frac_sel = {MAN_W{1'b0}};
        w_guard    = 1'b0;
        w_sticky   = 1'b0;
        if (r_acc[P_W-1]) begin
            w_frac_sel = r_acc[P_W-2:M];
            w_guard    = r_acc[M-1];
            w_sticky   = |r_acc[M-2:0];
        end else begin
            w_frac_sel = r_acc[P_W-3:M-1];
            w_guard    = r_acc[M-2];
            w_sticky   = |r_acc[M-3:0];
        end
    end

    logic w_round_up;
`ifdef FP_MUL_RNE_EN
    assign w_round_up = w_guard & (w_sticky | w_frac_sel[0]);
`else
    // Truncation: guard/sticky are computed but can never cause a round-up
    assign w_round_up = 1'b0 & w_guard & w_sticky;
`endif

    // Fraction overflow from rounding (1.11..1 + ulp) carries into the exponent;
    // the low fraction bits are then all zero, as required.
    logic [MAN_W:0]            w_frac_rnd;
    logic signed [EXP_W+1:0]   w_exp_raw;
    logic signed [EXP_W+1:0]   w_exp_norm;
    logic signed [EXP_W+1:0]   w_exp_fin;

    assign w_frac_rnd = {1'b0, w_frac_sel} + {{MAN_W{1'b0}}, w_round_up};
    assign w_exp_raw  = $signed({2'b00, w_a_exp}) + $signed({2'b00, w_b_exp}) - BIAS_S;
    assign w_exp_norm = w_exp_raw + (r_acc[P_W-1] ? ONE_S : ZERO_S);
    assign w_exp_fin  = w_exp_norm + (w_frac_rnd[MAN_W] ? ONE_S : ZERO_S);

    logic [W-1:0] w_norm_result;
    logic         w_ovf;
    logic         w_unf;

    // Range check: saturate to Inf or flush to zero outside the normal range
    always_comb begin
        w_ovf         = 1'b0;
        w_unf         = 1'b0;
        w_norm_result = {w_sign, w_exp_fin[EXP_W-1:0], w_frac_rnd[MAN_W-1:0]};
        if (w_exp_fin >= EXP_INF_S) begin
            w_norm_result = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_ovf         = 1'b1;
        end else if (w_exp_fin <= ZERO_S) begin
            w_norm_result = {w_sign, {(W-1){1'b0}}};
            w_unf         = 1'b1;
        end else begin
            w_ovf         = 1'b0;
            w_unf         = 1'b0;
        end
    end

    // Control FSM and datapath registers. Special results ride through the
    // NORM slot untouched so they leave two cycles after accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_a         <= {W{1'b0}};
            r_b         <= {W{1'b0}};
            r_mplier    <= {M{1'b0}};
            r_acc       <= {P_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_special   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= {W{1'b0}};
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_ovf      <= 1'b0;
                        r_unf      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_CHECK;
                    end else begin
                        r_state    <= S_IDLE;
                    end
                end
                S_CHECK: begin
                    if (w_is_special) begin
                        r_special <= 1'b1;
                        r_result  <= w_spec_val;
                        r_state   <= S_NORM;
                    end else begin
                        r_special <= 1'b0;
                        r_acc     <= {P_W{1'b0}};
                        r_mplier  <= {1'b1, w_b_frac};
                        r_cnt     <= {CNT_W{1'b0}};
                        r_state   <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_acc    <= {w_sum, r_acc[M-1:1]};
                    r_mplier <= {1'b0, r_mplier[M-1:1]};
                    if (r_cnt == CNT_W'(M - 1)) begin
                        r_state <= S_NORM;
                    end else begin
                        r_cnt   <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_NORM: begin
                    if (!r_special) begin
                        r_result <= w_norm_result;
                        r_ovf    <= w_ovf;
                        r_unf    <= w_unf;
                    end else begin
                        r_ovf    <= 1'b0;
                        r_unf    <= 1'b0;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_state     <= S_DONE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule

// File: tb/tb_fp_mul_iter.sv
// Directed bench for fp_mul_iter: binary32 and binary64 instances, with a
// queue of expected results filled at issue time and drained at output time.
module tb_fp_mul_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_ovf, s_unf;
    logic [31:0] s_a, s_b, s_result;
    logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_ovf, d_unf;
    logic [63:0] d_a, d_b, d_result;

    fp_mul_iter #(.EXP_W(8), .MAN_W(23)) u_sp (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a), .b(s_b),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result),
        .overflow(s_ovf), .underflow(s_unf)
    );

    fp_mul_iter #(.EXP_W(11), .MAN_W(52)) u_dp (
        .clk(clk), .rst(rst),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .a(d_a), .b(d_b),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .result(d_result),
        .overflow(d_ovf), .underflow(d_unf)
    );

    typedef struct {
        logic [63:0] res;
        logic        ov;
        logic        un;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait for in_ready, present one operand pair for one edge, queue the expectation
    task automatic issue(input bit dp, input logic [63:0] x, input logic [63:0] y,
                         input logic [63:0] er, input logic eo, input logic eu, input int el);
        int n = 0;
        while (((dp ? d_in_ready : s_in_ready) !== 1'b1) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_timeout", 64'(n >= 100), 64'd0);
        if (dp) begin
            d_a = x; d_b = y; d_in_valid = 1'b1;
        end else begin
            s_a = x[31:0]; s_b = y[31:0]; s_in_valid = 1'b1;
        end
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        d_in_valid = 1'b0;
        s_a = $urandom; s_b = $urandom;
        d_a = {$urandom, $urandom}; d_b = {$urandom, $urandom};
        sb.push_back('{er, eo, eu, el});
    endtask

    // Wait for out_valid, counting edges since accept, and compare against the queue head
    task automatic collect(input bit dp, input bit handoff, input string tag);
        int          lat = 0;
        exp_t        e;
        logic [63:0] r;
        logic        o, u;
        while (((dp ? d_out_valid : s_out_valid) !== 1'b1) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (dp) begin
            r = d_result; o = d_ovf; u = d_unf;
        end else begin
            r = {32'd0, s_result}; o = s_ovf; u = s_unf;
        end
        e = sb.pop_front();
        chk({tag, ".res"}, r, e.res);
        chk({tag, ".ovf"}, 64'(o), 64'(e.ov));
        chk({tag, ".unf"}, 64'(u), 64'(e.un));
        chk({tag, ".lat"}, 64'(lat), 64'(e.lat));
        if (handoff) begin
            @(posedge clk); #1;
            chk({tag, ".back_idle"}, 64'(dp ? d_in_ready : s_in_ready), 64'd1);
        end
    endtask

    logic [63:0] rne_exp;
    int          seen;

    initial begin
        rst = 1'b0;
        s_in_valid = 1'b0; s_a = 32'd0; s_b = 32'd0; s_out_ready = 1'b1;
        d_in_valid = 1'b0; d_a = 64'd0; d_b = 64'd0; d_out_ready = 1'b1;
`ifdef FP_MUL_RNE_EN
        rne_exp = 64'h0000_0000_4010_0002;
`else
        rne_exp = 64'h0000_0000_4010_0001;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready",  64'(s_in_ready), 64'd1);
        chk("rst.out_valid", 64'(s_out_valid), 64'd0);
        chk("rst.result",    64'(s_result), 64'd0);
        chk("rst.flags",     64'({s_ovf, s_unf}), 64'd0);
        chk("rst.dp_ready",  64'(d_in_ready), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;

        // binary32 directed cases
        issue(0, 64'h4000_0000, 64'h4040_0000, 64'h40C0_0000, 1'b0, 1'b0, 26); collect(0, 1, "mul_2x3");
        issue(0, 64'h0000_0000, 64'h7F80_0000, 64'h7FC0_0000, 1'b0, 1'b0, 2);  collect(0, 1, "zero_x_inf");
        issue(0, 64'hFF80_0000, 64'h4000_0000, 64'hFF80_0000, 1'b0, 1'b0, 2);  collect(0, 1, "ninf_x_2");
        issue(0, 64'h7F00_0000, 64'h4000_0000, 64'h7F80_0000, 1'b1, 1'b0, 26); collect(0, 1, "overflow");
        issue(0, 64'h7F00_0000, 64'h3F80_0000, 64'h7F00_0000, 1'b0, 1'b0, 26); collect(0, 1, "max_exp_ok");
        issue(0, 64'h0080_0000, 64'h0080_0000, 64'h0000_0000, 1'b0, 1'b1, 26); collect(0, 1, "underflow");
        issue(0, 64'h0080_0000, 64'h3F80_0000, 64'h0080_0000, 1'b0, 1'b0, 26); collect(0, 1, "min_norm_ok");
        issue(0, 64'h2000_0000, 64'h1F80_0000, 64'h0000_0000, 1'b0, 1'b1, 26); collect(0, 1, "exp_zero_unf");
        issue(0, 64'h3FC0_0001, 64'h3FC0_0001, rne_exp,       1'b0, 1'b0, 26); collect(0, 1, "rounding");
        issue(0, 64'hC000_0000, 64'h4040_0000, 64'hC0C0_0000, 1'b0, 1'b0, 26); collect(0, 1, "neg_sign");
        issue(0, 64'h7FC1_2345, 64'h3F80_0000, 64'h7FC0_0000, 1'b0, 1'b0, 2);  collect(0, 1, "nan_in");
        issue(0, 64'hFF80_0000, 64'h8000_0000, 64'h7FC0_0000, 1'b0, 1'b0, 2);  collect(0, 1, "ninf_x_nzero");
        issue(0, 64'h8000_0000, 64'h3F80_0000, 64'h8000_0000, 1'b0, 1'b0, 2);  collect(0, 1, "neg_zero");
        issue(0, 64'h0000_0001, 64'h4000_0000, 64'h0000_0000, 1'b0, 1'b0, 2);  collect(0, 1, "subnorm_flush");
        issue(0, 64'h3FFF_FFFF, 64'h3FFF_FFFF, 64'h407F_FFFE, 1'b0, 1'b0, 26); collect(0, 1, "all_ones_frac");

        // Backpressure: result held, no accept while stalled
        s_out_ready = 1'b0;
        issue(0, 64'h4000_0000, 64'h4040_0000, 64'h40C0_0000, 1'b0, 1'b0, 26);
        collect(0, 0, "bp");
        for (int i = 0; i < 10; i++) begin
            s_in_valid = 1'b1; s_a = 32'h3F80_0000; s_b = 32'h3F80_0000;
            @(posedge clk); #1;
            chk("bp.hold_res",   64'(s_result), 64'h40C0_0000);
            chk("bp.hold_valid", 64'(s_out_valid), 64'd1);
            chk("bp.in_ready",   64'(s_in_ready), 64'd0);
        end
        s_in_valid = 1'b0;
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.release_valid", 64'(s_out_valid), 64'd0);
        chk("bp.release_ready", 64'(s_in_ready), 64'd1);
        issue(0, 64'h3F80_0000, 64'h4000_0000, 64'h4000_0000, 1'b0, 1'b0, 26); collect(0, 1, "after_bp");

        // binary64
        issue(1, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 64'h4018_0000_0000_0000, 1'b0, 1'b0, 55);
        collect(1, 1, "dp_2x3");
        issue(1, 64'h3FF0_0000_0000_0000, 64'hC000_0000_0000_0000, 64'hC000_0000_0000_0000, 1'b0, 1'b0, 55);
        collect(1, 1, "dp_1xm2");

        // Reset in the middle of the multiply loop aborts the operation
        issue(0, 64'h4000_0000, 64'h4040_0000, 64'h40C0_0000, 1'b0, 1'b0, 26);
        sb.delete();
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst.out_valid", 64'(s_out_valid), 64'd0);
        chk("midrst.result",    64'(s_result), 64'd0);
        chk("midrst.flags",     64'({s_ovf, s_unf}), 64'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst.in_ready", 64'(s_in_ready), 64'd1);
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (s_out_valid === 1'b1) seen++;
        end
        chk("midrst.no_output", 64'(seen), 64'd0);
        issue(0, 64'h4040_0000, 64'h4040_0000, 64'h4110_0000, 1'b0, 1'b0, 26); collect(0, 1, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
